forward_hazard_unit: RTL and testbench

- Parametrised forwarding and load-use hazard unit for the five-stage MIPS pipeline and its deeper variants.
- Keeps its own shift pipeline of destination tags, one entry per instruction from EX through the last forwarding stage.
- Resolves forwarding for every EX-stage source operand independently, youngest producer first.
- Detects load-use hazards for the instruction in ID and keeps a saturating stall counter for performance monitoring.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/fwd_tag_pipe.sv | 29 ++
 rtl/forward_hazard_unit.sv | 101 ++++++++++
 tb/tb_forward_hazard_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
package hazard_pkg;

    // Widest register address the tag entry can carry; AW must not exceed it.
    localparam int MAX_AW = 8;

    // Select code meaning "read the operand from the register file".
    localparam int FWD_SEL_RF = 0;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              isLoad;
        logic [MAX_AW-1:0] rd;
    } tagEntry_t;

    // Width of one forwarding select field: codes 0..depth.
    function automatic int selWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_tag_pipe.sv
// Shift register of destination tags, stage 0 = EX, stage DEPTH = last forwarding stage.
module fwd_tag_pipe
    import hazard_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      hold,
    input  logic      bubble,
    input  tagEntry_t inTag,
    output tagEntry_t stages [0:DEPTH]
);

    // Advance every tag one stage unless frozen; stage 0 takes the ID tag or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= DEPTH; k++) begin
                stages[k] <= '0;
            end
        end else if (!hold) begin
            stages[0] <= bubble ? tagEntry_t'('0) : inTag;
            for (int k = 1; k <= DEPTH; k++) begin
                stages[k] <= stages[k-1];
            end
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding select and load-use stall generation for a MIPS-style pipeline,
// with a saturating stall counter for performance monitoring.
module forward_hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int AW        = 5,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 2,
    parameter int CNT_W     = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   hold,
    input  logic                                   flush,
    input  logic                                   id_regwrite,
    input  logic                                   id_is_load,
    input  logic [AW-1:0]                          id_rd,
    input  logic [NUM_SRC*AW-1:0]                  id_src,
    input  logic [NUM_SRC-1:0]                     id_src_used,
    input  logic [NUM_SRC*AW-1:0]                  ex_src,
    output logic [NUM_SRC*selWidth(FWD_DEPTH)-1:0] fwd_sel,
    output logic                                   load_use_stall,
    output logic [CNT_W-1:0]                       stall_cnt
);

    localparam int SELW = selWidth(FWD_DEPTH);

    tagEntry_t idTag;
    tagEntry_t stages [0:FWD_DEPTH];
    logic      insertBubble;

    // A stage supplies a forwardable result for src when it writes a real register equal to src.
    function automatic logic producesReg(input tagEntry_t t, input logic [AW-1:0] src);
        return t.valid && t.regwrite && (t.rd != '0) && (t.rd == MAX_AW'(src));
    endfunction

    // A stage blocks an ID reader of src when it is a load targeting that register.
    function automatic logic pendingLoad(input tagEntry_t t, input logic [AW-1:0] src);
        return t.valid && t.isLoad && (t.rd != '0) && (t.rd == MAX_AW'(src));
    endfunction

    // Package the ID-stage instruction into a tag for stage 0.
    always_comb begin
        idTag          = '0;
        idTag.valid    = 1'b1;
        idTag.regwrite = id_regwrite;
        idTag.isLoad   = id_is_load;
        idTag.rd       = MAX_AW'(id_rd);
    end

    assign insertBubble = flush | load_use_stall;

    fwd_tag_pipe #(
        .DEPTH (FWD_DEPTH)
    ) tagPipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (hold),
        .bubble (insertBubble),
        .inTag  (idTag),
        .stages (stages)
    );

    // Per operand, scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd_sel[i*SELW +: SELW] = SELW'(FWD_SEL_RF);
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (producesReg(stages[k], ex_src[i*AW +: AW])) begin
                    fwd_sel[i*SELW +: SELW] = SELW'(k);
                end
            end
        end
    end

    // Stall ID when a used source depends on a load whose data is not yet forwardable.
    always_comb begin
        load_use_stall = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used[i]) begin
                for (int k = 0; k + 1 < LOAD_LAT; k++) begin
                    if (pendingLoad(stages[k], id_src[i*AW +: AW])) begin
                        load_use_stall = 1'b1;
                    end
                end
            end
        end
    end

    // Count honoured stall cycles, saturating at all-ones and frozen while the pipe holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!hold && load_use_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed self-checking bench for forward_hazard_unit.
module tb_forward_hazard_unit;

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic        flush;
    logic        id_regwrite;
    logic        id_is_load;
    logic [4:0]  id_rd;
    logic [9:0]  id_src;
    logic [1:0]  id_src_used;
    logic [9:0]  ex_src;
    logic [3:0]  fwd_sel;
    logic        load_use_stall;
    logic [15:0] stall_cnt;
    logic [3:0]  fwd_sel4;
    logic        load_use_stall4;
    logic [3:0]  stall_cnt4;

    int checks = 0;
    int errors = 0;

    forward_hazard_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hold           (hold),
        .flush          (flush),
        .id_regwrite    (id_regwrite),
        .id_is_load     (id_is_load),
        .id_rd          (id_rd),
        .id_src         (id_src),
        .id_src_used    (id_src_used),
        .ex_src         (ex_src),
        .fwd_sel        (fwd_sel),
        .load_use_stall (load_use_stall),
        .stall_cnt      (stall_cnt)
    );

    forward_hazard_unit #(
        .CNT_W (4)
    ) dut4 (
        .clk            (clk),
        .rst_n          (rst_n),
        .hold           (hold),
        .flush          (flush),
        .id_regwrite    (id_regwrite),
        .id_is_load     (id_is_load),
        .id_rd          (id_rd),
        .id_src         (id_src),
        .id_src_used    (id_src_used),
        .ex_src         (ex_src),
        .fwd_sel        (fwd_sel4),
        .load_use_stall (load_use_stall4),
        .stall_cnt      (stall_cnt4)
    );

    // Free-running clock, posedge at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rw, input logic ld, input logic [4:0] rd,
                                 input logic [4:0] s0, input logic [4:0] s1,
                                 input logic [1:0] used);
        id_regwrite = rw;
        id_is_load  = ld;
        id_rd       = rd;
        id_src      = {s1, s0};
        id_src_used = used;
        #1;
    endtask

    task automatic setEx(input logic [4:0] s0, input logic [4:0] s1);
        ex_src = {s1, s0};
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkSels(input string tag, input logic [1:0] e0, input logic [1:0] e1);
        checkOutput({tag, "_sel0"}, 32'(fwd_sel[1:0]), 32'(e0));
        checkOutput({tag, "_sel1"}, 32'(fwd_sel[3:2]), 32'(e1));
    endtask

    initial begin
        rst_n = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        ex_src = '0;
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
        checkSels("reset", 2'd0, 2'd0);
        checkOutput("reset_stall", 32'(load_use_stall), 32'd0);
        checkOutput("reset_cnt", 32'(stall_cnt), 32'd0);
        #10;
        rst_n = 1'b1;

        // Back-to-back ALU: sub $2,$1,$3 then and $12,$2,$5 then or $13,$6,$2
        applyStimulus(1'b1, 1'b0, 5'd2, 5'd1, 5'd3, 2'b11);
        tick();
        applyStimulus(1'b1, 1'b0, 5'd12, 5'd2, 5'd5, 2'b11);
        checkOutput("alu_nostall", 32'(load_use_stall), 32'd0);
        tick();
        setEx(5'd2, 5'd5);
        checkSels("and_ex", 2'd1, 2'd0);
        applyStimulus(1'b1, 1'b0, 5'd13, 5'd6, 5'd2, 2'b11);
        tick();
        setEx(5'd6, 5'd2);
        checkSels("or_ex", 2'd0, 2'd2);

        // Double hazard: two writers of $4, youngest wins
        applyStimulus(1'b1, 1'b0, 5'd4, 5'd0, 5'd0, 2'b00);
        tick();
        applyStimulus(1'b1, 1'b0, 5'd4, 5'd0, 5'd0, 2'b00);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
        tick();
        setEx(5'd4, 5'd4);
        checkSels("dbl_same", 2'd1, 2'd1);
        applyStimulus(1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 2'b00);
        tick();
        applyStimulus(1'b1, 1'b0, 5'd4, 5'd0, 5'd0, 2'b00);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
        tick();
        setEx(5'd4, 5'd7);
        checkSels("dbl_diff", 2'd1, 2'd2);

        // $0 destination and disabled writes never forward
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 2'b00);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
        tick();
        setEx(5'd0, 5'd5);
        checkSels("zero_nowr", 2'd0, 2'd0);

        // Load-use: lw $8 then add $9,$8,$1
        applyStimulus(1'b1, 1'b1, 5'd8, 5'd29, 5'd0, 2'b01);
        tick();
        setEx(5'd29, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd9, 5'd8, 5'd1, 2'b11);
        checkOutput("lu_stall", 32'(load_use_stall), 32'd1);
        checkOutput("lu_cnt0", 32'(stall_cnt), 32'd0);
        tick();
        checkOutput("lu_bubble", 32'(load_use_stall), 32'd0);
        checkOutput("lu_cnt1", 32'(stall_cnt), 32'd1);
        tick();
        setEx(5'd8, 5'd1);
        checkSels("lu_fwd", 2'd2, 2'd0);

        // Same dependency with the operand unused: no stall
        applyStimulus(1'b1, 1'b1, 5'd8, 5'd29, 5'd0, 2'b01);
        tick();
        applyStimulus(1'b1, 1'b0, 5'd9, 5'd8, 5'd1, 2'b00);
        checkOutput("lu_unused", 32'(load_use_stall), 32'd0);
        tick();
        checkOutput("lu_unused_cnt", 32'(stall_cnt), 32'd1);

        // Hold while a stall is pending: tags and counter frozen
        applyStimulus(1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 2'b00);
        tick();
        applyStimulus(1'b1, 1'b1, 5'd10, 5'd0, 5'd0, 2'b00);
        tick();
        applyStimulus(1'b1, 1'b0, 5'd11, 5'd0, 5'd10, 2'b10);
        setEx(5'd3, 5'd0);
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checkOutput("hold_stall", 32'(load_use_stall), 32'd1);
            checkOutput("hold_cnt", 32'(stall_cnt), 32'd1);
            checkSels("hold_tags", 2'd1, 2'd0);
            tick();
        end

        // Release hold with flush while stalling: bubble plus count
        hold  = 1'b0;
        flush = 1'b1;
        #1;
        checkOutput("hf_stall", 32'(load_use_stall), 32'd1);
        tick();
        flush = 1'b0;
        setEx(5'd3, 5'd10);
        checkOutput("hf_cnt", 32'(stall_cnt), 32'd2);
        checkOutput("hf_nostall", 32'(load_use_stall), 32'd0);
        checkSels("hf_shift", 2'd2, 2'd1);

        // Plain flush: squashed writer of $14 never forwards
        applyStimulus(1'b1, 1'b0, 5'd14, 5'd0, 5'd0, 2'b00);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
        tick();
        setEx(5'd14, 5'd14);
        checkSels("flush_kill", 2'd0, 2'd0);

        // Asynchronous reset mid-stream with a forward and stall pending
        applyStimulus(1'b1, 1'b0, 5'd20, 5'd0, 5'd0, 2'b00);
        tick();
        applyStimulus(1'b1, 1'b1, 5'd21, 5'd0, 5'd0, 2'b00);
        tick();
        applyStimulus(1'b1, 1'b0, 5'd22, 5'd21, 5'd0, 2'b01);
        setEx(5'd20, 5'd0);
        checkSels("pre_rst", 2'd1, 2'd0);
        checkOutput("pre_rst_stall", 32'(load_use_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        checkSels("async_rst", 2'd0, 2'd0);
        checkOutput("async_rst_stall", 32'(load_use_stall), 32'd0);
        checkOutput("async_rst_cnt", 32'(stall_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_cnt", 32'(stall_cnt), 32'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
        tick();
        setEx(5'd22, 5'd20);
        checkSels("post_rst", 2'd1, 2'd0);

        // Twenty honoured stalls: 16-bit counter reaches 20, 4-bit saturates at 15
        for (int n = 0; n < 20; n++) begin
            applyStimulus(1'b1, 1'b1, 5'd8, 5'd0, 5'd0, 2'b00);
            tick();
            applyStimulus(1'b1, 1'b0, 5'd9, 5'd8, 5'd0, 2'b01);
            tick();
            if (n == 14) begin
                checkOutput("sat_cnt4_15", 32'(stall_cnt4), 32'd15);
            end
        end
        checkOutput("sat_cnt16", 32'(stall_cnt), 32'd20);
        checkOutput("sat_cnt4", 32'(stall_cnt4), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
